// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, forwards DA..payload as {active,data},
// withholds the FCS, and reports CRC/length/rx_er status once per frame.
module gmii_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MAX = 7
) (
  input  logic        eth_rxck,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd_i,
  input  logic        gmii_rxctl_i,
  input  logic        gmii_rxer_i,
  output logic [8:0]  rxd_o,
  output logic        frame_end_o,
  output logic        frame_ok_o,
  output logic [10:0] frame_len_o,
  output logic [15:0] crc_err_cnt_o
);

  localparam int          PW      = $clog2(PRE_MAX + 1) + 1;
  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [7:0]  PRE_B   = 8'h55;
  localparam logic [7:0]  SFD_B   = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    ENDF,
    DROP
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   pre_cnt, pre_next;
  logic            start, beat, close;
  logic [31:0]     crc;
  logic [10:0]     byte_cnt;
  logic            err;
  logic [3:0][7:0] sh;
  logic            crc_good, len_good;

  // Reflected CRC-32, LSB-first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_ff @(posedge eth_rxck) begin
    if (rst) begin
      state   <= IDLE;
      pre_cnt <= '0;
    end else begin
      state   <= state_next;
      pre_cnt <= pre_next;
    end
  end

  always_comb begin
    state_next = state;
    pre_next   = pre_cnt;
    start      = 1'b0;
    beat       = 1'b0;
    close      = 1'b0;
    case (state)
      // The End cycle decodes exactly like Idle so a preamble can follow immediately.
      IDLE, ENDF: begin
        state_next = IDLE;
        if (gmii_rxctl_i) begin
          if (gmii_rxd_i == PRE_B) begin
            state_next = PRE;
            pre_next   = PW'(1);
          end else begin
            state_next = DROP;
          end
        end
      end
      PRE: begin
        if (!gmii_rxctl_i) begin
          state_next = IDLE;
        end else if (gmii_rxd_i == PRE_B) begin
          if (pre_cnt >= PW'(PRE_MAX)) state_next = DROP;
          else                         pre_next   = pre_cnt + PW'(1);
        end else if (gmii_rxd_i == SFD_B) begin
          state_next = DATA;
          start      = 1'b1;
        end else begin
          state_next = DROP;
        end
      end
      DATA: begin
        if (gmii_rxctl_i) begin
          beat = 1'b1;
        end else begin
          state_next = ENDF;
          close      = 1'b1;
        end
      end
      DROP: begin
        if (!gmii_rxctl_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign crc_good = (crc == RESIDUE);
  assign len_good = (byte_cnt >= MIN_L) && (byte_cnt <= MAX_L);

  always_ff @(posedge eth_rxck) begin
    if (rst) begin
      rxd_o         <= '0;
      frame_end_o   <= 1'b0;
      frame_ok_o    <= 1'b0;
      frame_len_o   <= '0;
      crc_err_cnt_o <= '0;
      crc           <= '1;
      byte_cnt      <= '0;
      err           <= 1'b0;
      sh            <= '0;
    end else begin
      frame_end_o <= close;
      frame_ok_o  <= close && crc_good && len_good && !err;
      // The four most recent bytes are held back so the FCS never leaves the block.
      rxd_o       <= (beat && byte_cnt >= 11'd4) ? {1'b1, sh[3]} : '0;
      if (close) begin
        frame_len_o <= byte_cnt;
        if (!crc_good && crc_err_cnt_o != '1) crc_err_cnt_o <= crc_err_cnt_o + 16'd1;
      end
      if (start) begin
        crc      <= '1;
        byte_cnt <= '0;
        err      <= 1'b0;
      end
      if (beat) begin
        crc <= crc_byte(crc, gmii_rxd_i);
        if (byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;
        sh  <= {sh[2:0], gmii_rxd_i};
        err <= err | gmii_rxer_i;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed/randomised bench for gmii_rx_deframer with a frame-level reference model.
module tb_gmii_rx_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  d   = '0;
  logic        ctl = 1'b0;
  logic        er  = 1'b0;
  logic [8:0]  rxd_o;
  logic        frame_end_o;
  logic        frame_ok_o;
  logic [10:0] frame_len_o;
  logic [15:0] crc_err_cnt_o;

  always #4 clk = ~clk;

  gmii_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1518), .PRE_MAX(7)) dut (
    .eth_rxck     (clk),
    .rst          (rst),
    .gmii_rxd_i   (d),
    .gmii_rxctl_i (ctl),
    .gmii_rxer_i  (er),
    .rxd_o        (rxd_o),
    .frame_end_o  (frame_end_o),
    .frame_ok_o   (frame_ok_o),
    .frame_len_o  (frame_len_o),
    .crc_err_cnt_o(crc_err_cnt_o)
  );

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [31:0] tbl[256];
  logic [7:0]  frm[$];

  // Standard Ethernet CRC-32 (inverted output) over frm[0..len-1], table driven.
  function automatic logic [31:0] fcs_of(int len);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < len; i++) c = tbl[c[7:0] ^ frm[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic [7:0] b, input logic e);
    ctl = c;
    d   = b;
    er  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/rxd"}, 32'(rxd_o), 32'd0);
    chk({tag, "/end"}, 32'(frame_end_o), 32'd0);
    chk({tag, "/ok"},  32'(frame_ok_o), 32'd0);
    chk({tag, "/cnt"}, 32'(crc_err_cnt_o), 32'(exp_cnt));
  endtask

  task automatic build(input int plen, input bit corrupt);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
    f = fcs_of(plen);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    if (corrupt) frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'h01;
  endtask

  // Drives preamble, SFD, frm[] and ifg idle cycles; checks every cycle.
  task automatic send_frame(input string tag, input int npre, input int rxer_idx, input int ifg);
    int  n;
    bit  fcs_ok;
    bit  exp_ok;
    n = frm.size();
    fcs_ok = (n >= 4) &&
             ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == fcs_of(n - 4));
    exp_ok = fcs_ok && (n >= 64) && (n <= 1518) && (rxer_idx < 0);
    for (int i = 0; i < npre; i++) begin
      step(1'b1, 8'h55, 1'b0);
      chk_quiet({tag, "/pre"});
    end
    step(1'b1, 8'hD5, 1'b0);
    chk_quiet({tag, "/sfd"});
    for (int j = 0; j < n; j++) begin
      step(1'b1, frm[j], (j == rxer_idx));
      if (j >= 4) chk({tag, "/fwd"}, 32'(rxd_o), 32'({1'b1, frm[j-4]}));
      else        chk({tag, "/hold"}, 32'(rxd_o), 32'd0);
      chk({tag, "/midend"}, 32'(frame_end_o), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0);
    if (!fcs_ok && exp_cnt < 65535) exp_cnt++;
    chk({tag, "/lastrxd"}, 32'(rxd_o), 32'd0);
    chk({tag, "/end"}, 32'(frame_end_o), 32'd1);
    chk({tag, "/ok"},  32'(frame_ok_o), 32'(exp_ok));
    chk({tag, "/len"}, 32'(frame_len_o), 32'((n > 2047) ? 2047 : n));
    chk({tag, "/cnt"}, 32'(crc_err_cnt_o), 32'(exp_cnt));
    for (int k = 1; k < ifg; k++) begin
      step(1'b0, 8'h00, 1'b0);
      chk_quiet({tag, "/ifg"});
    end
  endtask

  // Raw rxd bytes with rxctl high, then a short idle; nothing may come out.
  task automatic send_junk(input string tag);
    for (int i = 0; i < frm.size(); i++) begin
      step(1'b1, frm[i], 1'b0);
      chk_quiet({tag, "/junk"});
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b0);
      chk_quiet({tag, "/junkidle"});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      tbl[i] = c;
    end

    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("reset/len", 32'(frame_len_o), 32'd0);
    chk_quiet("reset");

    build(60, 1'b0);  send_frame("good60", 7, -1, 12);
    build(60, 1'b1);  send_frame("badfcs", 7, -1, 12);
    build(60, 1'b0);  send_frame("rxer", 7, 30, 12);

    frm = {8'h55, 8'h55, 8'h12};
    for (int i = 0; i < 8; i++) frm.push_back(8'($urandom));
    send_junk("badpre");
    build(60, 1'b0);  send_frame("afterdrop", 7, -1, 12);

    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 10; i++) frm.push_back(8'($urandom));
    send_junk("longpre");

    for (int i = 0; i < 7; i++) begin
      step(1'b1, 8'h55, 1'b0);
      chk_quiet("sfddrop/pre");
    end
    step(1'b0, 8'hD5, 1'b0);
    chk_quiet("sfddrop/sfd");
    step(1'b0, 8'h00, 1'b0);
    chk_quiet("sfddrop/idle");

    build(70, 1'b0);  send_frame("b2b_a", 7, -1, 12);
    build(80, 1'b0);  send_frame("b2b_b", 7, -1, 1);
    build(64, 1'b0);  send_frame("inend", 7, -1, 3);

    frm.delete();
    for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
    send_frame("short3", 7, -1, 4);

    build(59, 1'b0);   send_frame("len63", 7, -1, 4);
    build(1514, 1'b0); send_frame("len1518", 7, -1, 4);
    build(1596, 1'b0); send_frame("len1600", 7, -1, 4);

    for (int r = 0; r < 4; r++) begin
      build(int'($urandom_range(60, 200)), r[0]);
      send_frame("rand", int'($urandom_range(1, 7)), -1, int'($urandom_range(1, 12)));
    end

    build(60, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hD5, 1'b0);
    for (int j = 0; j < 30; j++) step(1'b1, frm[j], 1'b0);
    rst = 1'b1;
    step(1'b1, frm[30], 1'b0);
    rst = 1'b0;
    exp_cnt = 0;
    chk("rstmid/len", 32'(frame_len_o), 32'd0);
    chk_quiet("rstmid");
    for (int j = 31; j < frm.size(); j++) begin
      step(1'b1, (frm[j] == 8'h55) ? 8'h56 : frm[j], 1'b0);
      chk_quiet("rstmid/tail");
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b0);
      chk_quiet("rstmid/idle");
    end
    build(60, 1'b0);  send_frame("afterrst", 7, -1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
